// File: rtl/omsp_spm_request_ctrl_pkg.sv
// Shared definitions for the SPM request sequencer: SPM control field codes,
// sequencer state encoding and key-length defaults.
package omsp_spm_request_ctrl_pkg;

   localparam int SPM_KEY_WORDS   = 8;
   localparam int SPM_KEY_TIMEOUT = 255;

   localparam logic [2:0] SPM_REQ_NONE      = 3'd0;
   localparam logic [2:0] SPM_REQ_PUB_START = 3'd1;
   localparam logic [2:0] SPM_REQ_PUB_END   = 3'd2;
   localparam logic [2:0] SPM_REQ_SEC_START = 3'd3;
   localparam logic [2:0] SPM_REQ_SEC_END   = 3'd4;
   localparam logic [2:0] SPM_REQ_ID        = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CREATE = 3'd1,
      ST_CHECK  = 3'd2,
      ST_KEY    = 3'd3,
      ST_ABORT  = 3'd4,
      ST_QUERY  = 3'd5,
      ST_QCAP   = 3'd6,
      ST_DONE   = 3'd7
   } spm_state_t;

   // A single-word key still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic field_valid(input logic [2:0] f);
      return (f >= SPM_REQ_PUB_START) && (f <= SPM_REQ_ID);
   endfunction

endpackage

// File: rtl/omsp_spm_request_ctrl.sv
// Initiator-side sequencer turning protect/unprotect/query pulses into the
// handshake sequences consumed by omsp_spm_control.
module omsp_spm_request_ctrl
   import omsp_spm_request_ctrl_pkg::*;
#(
   parameter int KEY_WORDS   = SPM_KEY_WORDS,
   parameter int KEY_TIMEOUT = SPM_KEY_TIMEOUT
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic        protect_req,
   input  logic        unprotect_req,
   input  logic        query_req,
   input  logic [15:0] query_sel,
   input  logic [2:0]  query_field,
   input  logic        kd_valid,
   input  logic [15:0] kd_word,
   output logic        kd_ready,
   input  logic        violation,
   input  logic [15:0] requested_data,
   input  logic        spm_data_select_valid,
   output logic        update_spm,
   output logic        enable_spm,
   output logic [2:0]  data_request,
   output logic [15:0] spm_data_select,
   output logic        write_key,
   output logic [15:0] key_in,
   output logic        spm_busy,
   output logic        cmd_busy,
   output logic        done,
   output logic        result_ok,
   output logic [15:0] result_data
);

   localparam int             WCW       = cnt_width(KEY_WORDS);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(KEY_WORDS - 1);
   localparam logic [7:0]     TMO_LIMIT = 8'(KEY_TIMEOUT);

   spm_state_t     r_state;
   logic [WCW-1:0] r_word_cnt;
   logic [7:0]     r_tmo_cnt;
   logic           r_is_protect;
   logic           r_kd_ready;
   logic           r_update_spm;
   logic           r_enable_spm;
   logic [2:0]     r_data_request;
   logic [15:0]    r_spm_data_select;
   logic           r_spm_busy;
   logic           r_cmd_busy;
   logic           r_done;
   logic           r_result_ok;
   logic [15:0]    r_result_data;

   logic           w_key_accept;
   logic [7:0]     w_tmo_inc;

   // The key word is consumed in the handshake cycle itself, so write_key is
   // the live AND of the registered ready and the engine's valid.
   assign w_key_accept = r_kd_ready & kd_valid;
   assign w_tmo_inc    = (r_tmo_cnt == 8'hFF) ? 8'hFF : r_tmo_cnt + 8'd1;

   assign kd_ready        = r_kd_ready;
   assign write_key       = w_key_accept;
   assign key_in          = w_key_accept ? kd_word : 16'h0000;
   assign update_spm      = r_update_spm;
   assign enable_spm      = r_enable_spm;
   assign data_request    = r_data_request;
   assign spm_data_select = r_spm_data_select;
   assign spm_busy        = r_spm_busy;
   assign cmd_busy        = r_cmd_busy;
   assign done            = r_done;
   assign result_ok       = r_result_ok;
   assign result_data     = r_result_data;

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state           <= ST_IDLE;
         r_word_cnt        <= '0;
         r_tmo_cnt         <= 8'd0;
         r_is_protect      <= 1'b0;
         r_kd_ready        <= 1'b0;
         r_update_spm      <= 1'b0;
         r_enable_spm      <= 1'b0;
         r_data_request    <= SPM_REQ_NONE;
         r_spm_data_select <= 16'h0000;
         r_spm_busy        <= 1'b0;
         r_cmd_busy        <= 1'b0;
         r_done            <= 1'b0;
         r_result_ok       <= 1'b0;
         r_result_data     <= 16'h0000;
      end else begin
         // Single-cycle strobes default low every cycle.
         r_update_spm      <= 1'b0;
         r_enable_spm      <= 1'b0;
         r_data_request    <= SPM_REQ_NONE;
         r_spm_data_select <= 16'h0000;
         r_done            <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (protect_req) begin
                  r_state      <= ST_CREATE;
                  r_is_protect <= 1'b1;
                  r_update_spm <= 1'b1;
                  r_enable_spm <= 1'b1;
                  r_cmd_busy   <= 1'b1;
               end else if (unprotect_req) begin
                  r_state      <= ST_CREATE;
                  r_is_protect <= 1'b0;
                  r_update_spm <= 1'b1;
                  r_cmd_busy   <= 1'b1;
               end else if (query_req) begin
                  r_cmd_busy <= 1'b1;
                  if (field_valid(query_field)) begin
                     r_state           <= ST_QUERY;
                     r_data_request    <= query_field;
                     r_spm_data_select <= query_sel;
                  end else begin
                     r_state       <= ST_DONE;
                     r_done        <= 1'b1;
                     r_result_ok   <= 1'b0;
                     r_result_data <= 16'h0000;
                  end
               end
            end

            ST_CREATE: begin
               if (r_is_protect) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
                  r_result_ok <= 1'b1;
               end
            end

            ST_CHECK: begin
               if (violation) begin
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
                  r_result_ok <= 1'b0;
               end else begin
                  r_state    <= ST_KEY;
                  r_spm_busy <= 1'b1;
                  r_kd_ready <= 1'b1;
                  r_word_cnt <= '0;
                  r_tmo_cnt  <= 8'd0;
               end
            end

            // An accepted word always beats a timeout on the same cycle.
            ST_KEY: begin
               if (w_key_accept) begin
                  r_tmo_cnt <= 8'd0;
                  if (r_word_cnt == LAST_WORD) begin
                     r_state     <= ST_DONE;
                     r_kd_ready  <= 1'b0;
                     r_spm_busy  <= 1'b0;
                     r_done      <= 1'b1;
                     r_result_ok <= 1'b1;
                  end else begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                  end
               end else begin
                  r_tmo_cnt <= w_tmo_inc;
                  if (w_tmo_inc == TMO_LIMIT) begin
                     r_state      <= ST_ABORT;
                     r_kd_ready   <= 1'b0;
                     r_update_spm <= 1'b1;
                  end
               end
            end

            ST_ABORT: begin
               r_state     <= ST_DONE;
               r_spm_busy  <= 1'b0;
               r_done      <= 1'b1;
               r_result_ok <= 1'b0;
            end

            ST_QUERY: begin
               r_state <= ST_QCAP;
            end

            ST_QCAP: begin
               r_state       <= ST_DONE;
               r_done        <= 1'b1;
               r_result_ok   <= spm_data_select_valid;
               r_result_data <= requested_data;
            end

            ST_DONE: begin
               r_state    <= ST_IDLE;
               r_cmd_busy <= 1'b0;
            end

            default: begin
               r_state    <= ST_IDLE;
               r_cmd_busy <= 1'b0;
               r_spm_busy <= 1'b0;
               r_kd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_omsp_spm_request_ctrl.sv
// Directed self-checking bench for omsp_spm_request_ctrl; cycle N means the
// Nth rising edge after the request was sampled.
module tb_omsp_spm_request_ctrl;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic        protect_req, unprotect_req, query_req;
   logic [15:0] query_sel;
   logic [2:0]  query_field;
   logic        kd_valid;
   logic [15:0] kd_word;
   logic        kd_ready;
   logic        violation;
   logic [15:0] requested_data;
   logic        spm_data_select_valid;
   logic        update_spm, enable_spm;
   logic [2:0]  data_request;
   logic [15:0] spm_data_select;
   logic        write_key;
   logic [15:0] key_in;
   logic        spm_busy, cmd_busy, done, result_ok;
   logic [15:0] result_data;

   int n_tests = 0;
   int n_fail  = 0;

   omsp_spm_request_ctrl dut (
      .mclk                  (mclk),
      .puc_rst               (puc_rst),
      .protect_req           (protect_req),
      .unprotect_req         (unprotect_req),
      .query_req             (query_req),
      .query_sel             (query_sel),
      .query_field           (query_field),
      .kd_valid              (kd_valid),
      .kd_word               (kd_word),
      .kd_ready              (kd_ready),
      .violation             (violation),
      .requested_data        (requested_data),
      .spm_data_select_valid (spm_data_select_valid),
      .update_spm            (update_spm),
      .enable_spm            (enable_spm),
      .data_request          (data_request),
      .spm_data_select       (spm_data_select),
      .write_key             (write_key),
      .key_in                (key_in),
      .spm_busy              (spm_busy),
      .cmd_busy              (cmd_busy),
      .done                  (done),
      .result_ok             (result_ok),
      .result_data           (result_data)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] packed_outs;
      packed_outs = {kd_ready, update_spm, enable_spm, write_key, spm_busy, cmd_busy, done, result_ok};
      check({tag, "_ctl"}, packed_outs, 32'h0);
      check({tag, "_dreq"}, {29'd0, data_request}, 32'h0);
      check({tag, "_dsel"}, {16'd0, spm_data_select}, 32'h0);
      check({tag, "_keyin"}, {16'd0, key_in}, 32'h0);
      check({tag, "_rdata"}, {16'd0, result_data}, 32'h0);
   endtask

   // Full protect with no violation and eight back-to-back key words.
   task automatic run_protect_full(input string tag);
      logic [15:0] w;
      kd_valid    = 1'b0;
      protect_req = 1'b1;
      tick();                         // cycle 1
      protect_req = 1'b0;
      check({tag, "_c1_upd"}, {31'd0, update_spm}, 32'd1);
      check({tag, "_c1_en"},  {31'd0, enable_spm}, 32'd1);
      tick();                         // cycle 2: CHECK
      check({tag, "_c2_upd"}, {31'd0, update_spm}, 32'd0);
      check({tag, "_c2_rdy"}, {31'd0, kd_ready},   32'd0);
      kd_valid = 1'b1;
      tick();                         // cycle 3: first key word
      for (int i = 0; i < 8; i++) begin
         w       = 16'h1111 * 16'(i + 1);
         kd_word = w;
         #1;
         check($sformatf("%s_wk%0d", tag, i),   {31'd0, write_key}, 32'd1);
         check($sformatf("%s_key%0d", tag, i),  {16'd0, key_in},    {16'd0, w});
         check($sformatf("%s_busy%0d", tag, i), {31'd0, spm_busy},  32'd1);
         tick();
      end
      kd_valid = 1'b0;
      // cycle 11
      check({tag, "_c11_done"}, {31'd0, done},      32'd1);
      check({tag, "_c11_ok"},   {31'd0, result_ok}, 32'd1);
      check({tag, "_c11_busy"}, {31'd0, spm_busy},  32'd0);
      check({tag, "_c11_rdy"},  {31'd0, kd_ready},  32'd0);
      tick();
      check({tag, "_idle_cmd"}, {31'd0, cmd_busy},  32'd0);
   endtask

   initial begin
      puc_rst = 1'b1;
      protect_req = 1'b0; unprotect_req = 1'b0; query_req = 1'b0;
      query_sel = 16'h0; query_field = 3'd0;
      kd_valid = 1'b0; kd_word = 16'h0;
      violation = 1'b0; requested_data = 16'h0; spm_data_select_valid = 1'b0;

      tick(); tick();
      check_all_zero("reset");
      puc_rst = 1'b0;
      tick();

      // Unprotect
      unprotect_req = 1'b1;
      tick();
      unprotect_req = 1'b0;
      check("unp_c1_upd", {31'd0, update_spm}, 32'd1);
      check("unp_c1_en",  {31'd0, enable_spm}, 32'd0);
      check("unp_c1_cmd", {31'd0, cmd_busy},   32'd1);
      check("unp_c1_done", {31'd0, done},      32'd0);
      tick();
      check("unp_c2_done", {31'd0, done},      32'd1);
      check("unp_c2_ok",   {31'd0, result_ok}, 32'd1);
      check("unp_c2_upd",  {31'd0, update_spm}, 32'd0);
      tick();
      check("unp_c3_done", {31'd0, done},      32'd0);
      check("unp_c3_okhold", {31'd0, result_ok}, 32'd1);

      // Protect, clean key stream
      run_protect_full("prot");

      // Protect with violation
      protect_req = 1'b1;
      tick();
      protect_req = 1'b0;
      check("viol_c1_upd", {31'd0, update_spm}, 32'd1);
      tick();                         // cycle 2: violation sampled
      violation = 1'b1;
      kd_valid  = 1'b1;
      kd_word   = 16'hDEAD;
      #1;
      check("viol_c2_wk", {31'd0, write_key}, 32'd0);
      tick();                         // cycle 3
      violation = 1'b0;
      check("viol_c3_done", {31'd0, done},      32'd1);
      check("viol_c3_ok",   {31'd0, result_ok}, 32'd0);
      check("viol_c3_wk",   {31'd0, write_key}, 32'd0);
      check("viol_c3_busy", {31'd0, spm_busy},  32'd0);
      kd_valid = 1'b0;
      tick();

      // Protect, key engine stalls after three words
      protect_req = 1'b1;
      tick();
      protect_req = 1'b0;
      tick();
      kd_valid = 1'b1;
      tick();                         // cycle 3
      for (int i = 0; i < 3; i++) begin
         kd_word = 16'hA000 + 16'(i);
         #1;
         check($sformatf("tmo_wk%0d", i), {31'd0, write_key}, 32'd1);
         tick();
      end
      kd_valid = 1'b0;                // stall cycles start at cycle 6
      for (int k = 0; k < 255; k++) begin
         if (k == 0)   check("tmo_stall_busy", {31'd0, spm_busy},   32'd1);
         if (k == 254) check("tmo_last_upd",   {31'd0, update_spm}, 32'd0);
         tick();
      end
      check("tmo_abort_upd",  {31'd0, update_spm}, 32'd1);
      check("tmo_abort_en",   {31'd0, enable_spm}, 32'd0);
      check("tmo_abort_busy", {31'd0, spm_busy},   32'd1);
      check("tmo_abort_rdy",  {31'd0, kd_ready},   32'd0);
      tick();
      check("tmo_done",      {31'd0, done},      32'd1);
      check("tmo_ok",        {31'd0, result_ok}, 32'd0);
      check("tmo_busy_drop", {31'd0, spm_busy},  32'd0);
      tick();

      // Query id 2, field id
      query_sel = 16'h0002; query_field = 3'd5; query_req = 1'b1;
      tick();
      query_req = 1'b0;
      check("q_c1_dreq", {29'd0, data_request},    32'd5);
      check("q_c1_dsel", {16'd0, spm_data_select}, 32'h0002);
      requested_data = 16'h0002; spm_data_select_valid = 1'b1;
      tick();
      check("q_c2_dreq", {29'd0, data_request}, 32'd0);
      tick();
      check("q_c3_done", {31'd0, done},        32'd1);
      check("q_c3_data", {16'd0, result_data}, 32'h0002);
      check("q_c3_ok",   {31'd0, result_ok},   32'd1);
      tick();

      // Query with invalid field code
      query_field = 3'd7; query_req = 1'b1;
      tick();
      query_req = 1'b0;
      check("qbad_done", {31'd0, done},        32'd1);
      check("qbad_ok",   {31'd0, result_ok},   32'd0);
      check("qbad_data", {16'd0, result_data}, 32'h0);
      check("qbad_dreq", {29'd0, data_request}, 32'd0);
      tick();

      // Query with select rejected by SPM control
      query_sel = 16'h0009; query_field = 3'd1; query_req = 1'b1;
      tick();
      query_req = 1'b0;
      check("qinv_dreq", {29'd0, data_request}, 32'd1);
      requested_data = 16'hBEEF; spm_data_select_valid = 1'b0;
      tick();
      tick();
      check("qinv_done", {31'd0, done},        32'd1);
      check("qinv_ok",   {31'd0, result_ok},   32'd0);
      check("qinv_data", {16'd0, result_data}, 32'hBEEF);
      tick();
      check("qinv_hold", {16'd0, result_data}, 32'hBEEF);

      // Simultaneous protect and query: protect wins
      query_field = 3'd5; protect_req = 1'b1; query_req = 1'b1;
      tick();
      protect_req = 1'b0; query_req = 1'b0;
      check("prio_upd",  {31'd0, update_spm},   32'd1);
      check("prio_en",   {31'd0, enable_spm},   32'd1);
      check("prio_dreq", {29'd0, data_request}, 32'd0);
      unprotect_req = 1'b1;           // dropped while busy
      tick();
      unprotect_req = 1'b0;
      violation = 1'b1;
      tick();
      violation = 1'b0;
      check("prio_done", {31'd0, done}, 32'd1);
      tick();
      check("drop_idle", {31'd0, cmd_busy}, 32'd0);
      tick();
      check("drop_noupd", {31'd0, update_spm}, 32'd0);

      // Reset after the fourth key word
      protect_req = 1'b1;
      tick();
      protect_req = 1'b0;
      tick();
      kd_valid = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         kd_word = 16'h5000 + 16'(i);
         tick();
      end
      check("rst_pre_busy", {31'd0, spm_busy}, 32'd1);
      puc_rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      tick();
      puc_rst  = 1'b0;
      kd_valid = 1'b0;
      tick();
      run_protect_full("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
